// File: rtl/wb_board_io.sv
// Wishbone-classic board I/O block: LED drive with blink modes, debounced
// push-buttons with sticky press events and a level interrupt.
module wb_board_io #(
  parameter int unsigned NUM_LED         = 2,
  parameter int unsigned NUM_BTN         = 1,
  parameter int unsigned BTN_ACTIVE_LOW  = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 24000,
  parameter int unsigned BLINK_DIV       = 12000000
) (
  input  logic               wb_clk,
  input  logic               wb_rst_n,
  input  logic [3:0]         wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  input  logic [NUM_BTN-1:0] btn_i,
  output logic [NUM_LED-1:0] led_o,
  output logic               irq_o
);

  localparam int unsigned MODE_W = 2 * NUM_LED;
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned BL_W   = $clog2(BLINK_DIV);
  localparam logic        RAW_IDLE = (BTN_ACTIVE_LOW != 0);

  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [NUM_BTN-1:0]  ev_q, ev_d;
  logic [NUM_BTN-1:0]  en_q, en_d;
  logic [NUM_BTN-1:0]  sync1_q, sync1_d;
  logic [NUM_BTN-1:0]  sync2_q, sync2_d;
  logic [NUM_BTN-1:0]  db_q, db_d;
  logic [DB_W-1:0]     db_cnt_q [NUM_BTN];
  logic [DB_W-1:0]     db_cnt_d [NUM_BTN];
  logic [BL_W-1:0]     blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [NUM_LED-1:0]  led_q, led_d;
  logic                irq_q, irq_d;

  logic                req_c, wr_c;
  logic [31:0]         wmask_c;
  logic [31:0]         rd_c;
  logic [NUM_BTN-1:0]  clr_c;
  logic [NUM_BTN-1:0]  pressed_c;
  logic [NUM_BTN-1:0]  rise_c;
  logic                unused_c;

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign led_o    = led_q;
  assign irq_o    = irq_q;
  assign unused_c = ^{wb_adr_i[1:0], wb_dat_i};

  // Bus decode: single-cycle ack, read mux, byte-lane writes.
  always_comb begin
    req_c   = wb_cyc_i & wb_stb_i & ~ack_q;
    wr_c    = req_c & wb_we_i;
    wmask_c = '0;
    rd_c    = '0;
    clr_c   = '0;
    mode_d  = mode_q;
    en_d    = en_q;
    for (int b = 0; b < 4; b++) begin
      wmask_c[8*b +: 8] = {8{wb_sel_i[b]}};
    end
    case (wb_adr_i[3:2])
      2'd0:    rd_c[MODE_W-1:0]  = mode_q;
      2'd1:    rd_c[NUM_BTN-1:0] = db_q;
      2'd2:    rd_c[NUM_BTN-1:0] = ev_q;
      default: rd_c[NUM_BTN-1:0] = en_q;
    endcase
    if (wr_c) begin
      case (wb_adr_i[3:2])
        2'd0: mode_d = (mode_q & ~wmask_c[MODE_W-1:0]) |
                       (wb_dat_i[MODE_W-1:0] & wmask_c[MODE_W-1:0]);
        2'd2: clr_c  = wb_dat_i[NUM_BTN-1:0] & wmask_c[NUM_BTN-1:0];
        2'd3: en_d   = (en_q & ~wmask_c[NUM_BTN-1:0]) |
                       (wb_dat_i[NUM_BTN-1:0] & wmask_c[NUM_BTN-1:0]);
        default: ;
      endcase
    end
    ack_d = req_c;
    dat_d = (req_c & ~wb_we_i) ? rd_c : 32'h0;
  end

  // Synchronize, debounce and capture press events (a new press beats W1C).
  always_comb begin
    sync1_d   = btn_i;
    sync2_d   = sync1_q;
    pressed_c = sync2_q ^ {NUM_BTN{RAW_IDLE}};
    db_d      = db_q;
    db_cnt_d  = db_cnt_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (pressed_c[i] == db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d[i]     = ~db_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
    rise_c = db_d & ~db_q;
    ev_d   = (ev_q & ~clr_c) | rise_c;
  end

  // Blink phase generator and registered LED / interrupt drive.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BL_W'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BL_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
    led_d = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      case (mode_q[2*i +: 2])
        2'b00:   led_d[i] = 1'b0;
        2'b01:   led_d[i] = 1'b1;
        2'b10:   led_d[i] = phase_q;
        default: led_d[i] = ~phase_q;
      endcase
    end
    irq_d = |(ev_q & en_q);
  end

  // State registers.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      mode_q      <= '0;
      ev_q        <= '0;
      en_q        <= '0;
      sync1_q     <= {NUM_BTN{RAW_IDLE}};
      sync2_q     <= {NUM_BTN{RAW_IDLE}};
      db_q        <= '0;
      for (int i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      led_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      mode_q      <= mode_d;
      ev_q        <= ev_d;
      en_q        <= en_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_q        <= db_d;
      for (int i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= db_cnt_d[i];
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
      irq_q       <= irq_d;
    end
  end

endmodule
